// File: rtl/fu_div_iter.sv
// Iterative radix-2 restoring divide/remainder unit (DIV/DIVU/REM/REMU) returning an issue tag.
// Optional macro FU_DIV_ZERO_FASTPATH_EN: divide-by-zero and signed overflow complete in one cycle.
module fu_div_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic             accept;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_neg, r_neg, op_rem_q, special_q;
    logic [WIDTH-1:0] special_res_q;
    logic [TAG_W-1:0] tag_q;

    // Accept-time operand conditioning; op[0] selects unsigned, op[1] selects remainder.
    logic             a_neg, b_neg, div_zero, overflow, special_now;
    logic [WIDTH-1:0] a_mag, b_mag, special_val;

    assign a_neg       = ~op[0] & A[WIDTH-1];
    assign b_neg       = ~op[0] & B[WIDTH-1];
    assign a_mag       = a_neg ? -A : A;
    assign b_mag       = b_neg ? -B : B;
    assign div_zero    = (B == '0);
    assign overflow    = ~op[0] & (A == INT_MIN) & (B == '1);
    assign special_now = div_zero | overflow;

    always_comb begin
        if (div_zero)
            special_val = op[1] ? A : '1;
        else
            special_val = op[1] ? '0 : A;
    end

    // One restoring step; the top bit of the extended difference is the borrow.
    logic [WIDTH+1:0] rem_sh, trial;
    logic             borrow;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {2'b00, dvs};
    assign borrow = trial[WIDTH+1];

    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign quo_fix = q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: accept = EN;
            CALC: begin
                busy = 1'b1;
                if (count == CNT_W'(1))
                    state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                accept     = EN;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
`ifdef FU_DIV_ZERO_FASTPATH_EN
            state_next = special_now ? DONE : CALC;
`else
            state_next = CALC;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            op_rem_q      <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            tag_q         <= '0;
            res           <= '0;
            tag_out       <= '0;
        end else if (accept) begin
            count         <= CNT_W'(WIDTH);
            rem           <= '0;
            quo           <= a_mag;
            dvs           <= b_mag;
            q_neg         <= a_neg ^ b_neg;
            r_neg         <= a_neg;
            op_rem_q      <= op[1];
            special_q     <= special_now;
            special_res_q <= special_val;
            tag_q         <= tag_in;
`ifdef FU_DIV_ZERO_FASTPATH_EN
            if (special_now) begin
                res     <= special_val;
                tag_out <= tag_in;
            end
`endif
        end else if (state == CALC) begin
            rem   <= borrow ? rem_sh[WIDTH:0] : trial[WIDTH:0];
            quo   <= {quo[WIDTH-2:0], ~borrow};
            count <= count - CNT_W'(1);
        end else if (state == FIX) begin
            res     <= special_q ? special_res_q : (op_rem_q ? rem_fix : quo_fix);
            tag_out <= tag_q;
        end
    end

endmodule
